// File: rtl/seq_divider_if.sv
// Request/response bundle for the multi-cycle divider.
// The master issues DIV/DIVU operands; the slave reports busy/done and results.
interface seq_divider_if #(
  parameter int N = 32
);
  logic         start;
  logic         is_signed;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring divider for DIV/DIVU: one quotient bit per clock,
// quotient to LO, remainder to HI, start/busy/done handshake.
module seq_divider #(
  parameter int N = 32
) (
  input logic         clk,
  input logic         reset,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FIX
  } state_t;

  state_t       state;
  logic [CW-1:0] cnt;
  logic [N-1:0] r;
  logic [N-1:0] q;
  logic [N-1:0] dmag;
  logic [N-1:0] raw_a;
  logic         neg_q;
  logic         neg_r;
  logic         dz_pend;

  logic         busy_q;
  logic         done_q;
  logic [N-1:0] quo_q;
  logic [N-1:0] rem_q;
  logic         dz_q;

  logic         a_neg;
  logic         b_neg;
  logic [N-1:0] a_mag;
  logic [N-1:0] b_mag;
  logic [N:0]   shifted;
  logic [N:0]   trial;

  always_comb begin
    a_neg   = bus.is_signed & bus.dividend[N-1];
    b_neg   = bus.is_signed & bus.divisor[N-1];
    a_mag   = a_neg ? -bus.dividend : bus.dividend;
    b_mag   = b_neg ? -bus.divisor : bus.divisor;
    // R stays below the divisor, so N bits hold it; the shift needs N+1
    shifted = {r, q[N-1]};
    trial   = shifted - {1'b0, dmag};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      r       <= '0;
      q       <= '0;
      dmag    <= '0;
      raw_a   <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz_pend <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= BUSY;
            busy_q  <= 1'b1;
            cnt     <= '0;
            r       <= '0;
            q       <= a_mag;
            dmag    <= b_mag;
            raw_a   <= bus.dividend;
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            dz_pend <= (bus.divisor == '0);
          end
        end
        BUSY: begin
          if (!trial[N]) begin
            r <= trial[N-1:0];
            q <= {q[N-2:0], 1'b1};
          end else begin
            r <= shifted[N-1:0];
            q <= {q[N-2:0], 1'b0};
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) state <= FIX;
        end
        FIX: begin
          // divide-by-zero returns the raw dividend with no sign fixup
          if (dz_pend) begin
            quo_q <= '1;
            rem_q <= raw_a;
          end else begin
            quo_q <= neg_q ? -q : q;
            rem_q <= neg_r ? -r : r;
          end
          dz_q   <= dz_pend;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dz_q;
endmodule
